// File: rtl/if_pkg.sv
// Shared types and constants for the decoupled instruction fetch unit.
// XLEN lives here so every fetch-path file agrees on the data/address width.
package if_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// Generic single-clock FIFO with synchronous clear; DEPTH must be a power of two.
// A push and a pop in the same cycle both take effect, even when the FIFO is full.
module fifo_sync #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  T                             din,
    input  logic                         pop,
    output T                             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T           mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupled instruction fetch: issues in-order split-transaction IRAM reads,
// buffers returned words in a FIFO and hands them to ID; redirects drop stale work.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET_ADDR   = '0,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_instruction,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              iram_req,
    output logic              iram_write,
    output logic [XLEN/8-1:0] iram_wstrb,
    output logic [XLEN-1:0]   iram_addr,
    output logic [XLEN-1:0]   iram_wdata,
    input  logic              iram_addr_ok,
    input  logic              iram_data_ok,
    input  logic [XLEN-1:0]   iram_rdata
);

    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int SW = CW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_base;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;
    logic [OW-1:0]   live_outstanding;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            credit_ok;
    logic            accept;
    logic            dropping;
    logic            push;
    logic            pop;
    logic            unused_low_bits;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign redirect_base    = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_low_bits  = ^redirect_pc[1:0];
    assign live_outstanding = outstanding - drop_cnt;

    // Every live request owns a FIFO slot before it is issued, so pushes never overflow.
    assign credit_ok = (SW'(fifo_count) + SW'(live_outstanding)) < SW'(FIFO_DEPTH);
    assign iram_req  = ~rst & ~redirect & (outstanding < OW'(MAX_OUTSTANDING)) & credit_ok;
    assign iram_addr = fetch_pc;
    assign accept    = iram_req & iram_addr_ok;

    assign iram_write = 1'b0;
    assign iram_wstrb = '0;
    assign iram_wdata = '0;

    // Responses return in request order; the oldest drop_cnt of them belong to a dead path.
    assign dropping   = iram_data_ok & (redirect | (drop_cnt != '0));
    assign push       = iram_data_ok & ~dropping;
    assign push_entry = '{pc: resp_pc, instruction: iram_rdata};

    // ID handshake: an entry moves when id_valid & id_ready on a clock edge; while
    // id_valid is high and id_ready low, id_pc/id_instruction hold. Redirect overrides.
    assign pop            = id_valid & id_ready & ~redirect;
    assign id_valid       = ~fifo_empty;
    assign id_pc          = head.pc;
    assign id_instruction = head.instruction;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= PC_RESET_ADDR;
            resp_pc     <= PC_RESET_ADDR;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + OW'(accept) - OW'(iram_data_ok);
            if (redirect) begin
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                drop_cnt <= outstanding - OW'(iram_data_ok);
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
                if (push)   resp_pc  <= resp_pc + XLEN'(INSTR_BYTES);
                if (iram_data_ok && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
            end
        end
    end

    fifo_sync #(
        .T     (fetch_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always @(posedge clk) begin
        if (!rst) assert (!(push && fifo_full && !pop));
    end

endmodule
